vec_regfile_alu: RTL and testbench

- Vector accelerator core: a register file of els_p vectors, each vlen_p elements of vdw_p bits, plus a lanes_p-wide element ALU.
- Accepts one command at a time over a valid/ready input handshake: write a vector, read a vector, or perform an elementwise add/sub/mul with result written back.
- Reads return data over a valid/yumi output handshake.
- Sits between the host command interface and storage; it is the top of the vector datapath.

---
 rtl/vec_regfile_alu.sv | 163 ++++++++++++++++
 tb/tb_vec_regfile_alu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vec_regfile_alu.sv
// Vector register file with a lanes_p-wide elementwise ALU behind a valid/ready command port.
// Define VEC_SCALAR_OPS_EN to build vector-scalar ops (op[3:2]=01); otherwise they are illegal.
module vec_regfile_alu #(
  parameter int unsigned els_p   = 8,
  parameter int unsigned vlen_p  = 4,
  parameter int unsigned vdw_p   = 4,
  parameter int unsigned lanes_p = 2,
  localparam int unsigned v_addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [v_addr_width_lp-1:0] addrA_i,
  input  logic [v_addr_width_lp-1:0] addrB_i,
  input  logic [v_addr_width_lp-1:0] addrC_i,
  input  logic [vdw_p-1:0]           scalar_i,
  input  logic [vlen_p*vdw_p-1:0]    w_data_i,
  input  logic [3:0]                 op_i,
  input  logic                       v_i,
  output logic                       ready_o,
  output logic                       done_o,
  output logic [vlen_p*vdw_p-1:0]    r_data_o,
  output logic                       v_o,
  input  logic                       yumi_i
);
  localparam int unsigned vw_lp     = vlen_p * vdw_p;
  localparam int unsigned chunks_lp = vlen_p / lanes_p;
  localparam int unsigned cnt_w_lp  = (chunks_lp > 1) ? $clog2(chunks_lp) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StRdout} state_e;
  typedef enum logic [1:0] {KWrite, KRead, KAlu, KIll} kind_e;

  state_e                     state_q, state_d;
  logic [cnt_w_lp-1:0]        cnt_q, cnt_d;
  logic                       done_q, done_d;
  logic [3:0]                 op_q;
  logic [v_addr_width_lp-1:0] addra_q, addrb_q, addrc_q;
  logic [vw_lp-1:0]           wdata_q, rdata_q;
  logic [vw_lp-1:0]           regs_q [els_p];
  kind_e                      kind;
  logic                       accept, last;

  logic [vdw_p-1:0]   a_el [lanes_p];
  logic [vdw_p-1:0]   b_el [lanes_p];
  logic [vdw_p-1:0]   alu_el [lanes_p];
  logic [vdw_p-1:0]   wr_el [lanes_p];
  logic [2*vdw_p-1:0] prod [lanes_p];
  int unsigned        pos [lanes_p];

`ifdef VEC_SCALAR_OPS_EN
  logic [vdw_p-1:0] scalar_q;
`else
  logic unused_scalar;
  assign unused_scalar = ^scalar_i;
`endif

  always_comb begin
    kind = KIll;
    if (op_q == 4'b1001) kind = KWrite;
    else if (op_q == 4'b1000) kind = KRead;
    else if (op_q[3:2] == 2'b00 && op_q[1:0] != 2'b11) kind = KAlu;
`ifdef VEC_SCALAR_OPS_EN
    else if (op_q[3:2] == 2'b01 && op_q[1:0] != 2'b11) kind = KAlu;
`endif
  end

  assign accept = (state_q == StIdle) && v_i;
  assign last   = (cnt_q == cnt_w_lp'(chunks_lp - 1));

  // Operands come from current contents, so in-place ops read old values before the write edge.
  always_comb begin
    for (int l = 0; l < lanes_p; l++) begin
      pos[l]  = (32'(cnt_q) * lanes_p + l) * vdw_p;
      a_el[l] = regs_q[addra_q][pos[l] +: vdw_p];
`ifdef VEC_SCALAR_OPS_EN
      b_el[l] = op_q[2] ? scalar_q : regs_q[addrb_q][pos[l] +: vdw_p];
`else
      b_el[l] = regs_q[addrb_q][pos[l] +: vdw_p];
`endif
      prod[l] = {{vdw_p{1'b0}}, a_el[l]} * {{vdw_p{1'b0}}, b_el[l]};
      case (op_q[1:0])
        2'b00:   alu_el[l] = a_el[l] + b_el[l];
        2'b01:   alu_el[l] = a_el[l] - b_el[l];
        2'b10:   alu_el[l] = prod[l][vdw_p-1:0];
        default: alu_el[l] = '0;
      endcase
      wr_el[l] = (kind == KWrite) ? wdata_q[pos[l] +: vdw_p] : alu_el[l];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (v_i) begin
          state_d = StBusy;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        if (kind == KIll || last) begin
          cnt_d = '0;
          if (kind == KRead) begin
            state_d = StRdout;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRdout: if (yumi_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      op_q    <= '0;
      addra_q <= '0;
      addrb_q <= '0;
      addrc_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef VEC_SCALAR_OPS_EN
      scalar_q <= '0;
`endif
      for (int i = 0; i < els_p; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (accept) begin
        op_q    <= op_i;
        addra_q <= addrA_i;
        addrb_q <= addrB_i;
        addrc_q <= addrC_i;
        wdata_q <= w_data_i;
`ifdef VEC_SCALAR_OPS_EN
        scalar_q <= scalar_i;
`endif
      end
      if (state_q == StBusy) begin
        for (int l = 0; l < lanes_p; l++) begin
          if (kind == KRead) rdata_q[pos[l] +: vdw_p] <= a_el[l];
          else if (kind == KWrite || kind == KAlu) regs_q[addrc_q][pos[l] +: vdw_p] <= wr_el[l];
        end
      end
    end
  end

  // Outputs are forced low while reset is held, even mid-operation.
  assign ready_o  = !reset_i && (state_q == StIdle);
  assign v_o      = !reset_i && (state_q == StRdout);
  assign done_o   = !reset_i && (done_q || ((state_q == StRdout) && yumi_i));
  assign r_data_o = reset_i ? '0 : rdata_q;

endmodule

// File: tb/tb_vec_regfile_alu.sv
// Randomized bench for vec_regfile_alu against a whole-vector reference model.
module tb_vec_regfile_alu;
  localparam int NCH = 2;

  logic        clk, reset;
  logic [2:0]  addr_a, addr_b, addr_c;
  logic [3:0]  scalar, op;
  logic [15:0] w_data, r_data;
  logic        v_in, ready, done, v_out, yumi;

  int checks = 0;
  int errors = 0;
  logic [15:0] ref_regs [8];

  vec_regfile_alu dut (
    .clk_i(clk), .reset_i(reset), .addrA_i(addr_a), .addrB_i(addr_b), .addrC_i(addr_c),
    .scalar_i(scalar), .w_data_i(w_data), .op_i(op), .v_i(v_in), .ready_o(ready),
    .done_o(done), .r_data_o(r_data), .v_o(v_out), .yumi_i(yumi)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 0 write, 1 read, 2 alu, 3 illegal
  function automatic int kind_of(input logic [3:0] o);
    if (o == 4'b1001) return 0;
    if (o == 4'b1000) return 1;
    if (o[3:2] == 2'b00 && o[1:0] != 2'b11) return 2;
`ifdef VEC_SCALAR_OPS_EN
    if (o[3:2] == 2'b01 && o[1:0] != 2'b11) return 2;
`endif
    return 3;
  endfunction

  function automatic logic [15:0] alu_ref(input logic [3:0] o, input logic [15:0] va,
                                          input logic [15:0] vb, input logic [3:0] sc);
    logic [15:0] r;
    int x, y, z;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      x = int'(va[i*4 +: 4]);
      y = o[2] ? int'(sc) : int'(vb[i*4 +: 4]);
      case (o[1:0])
        2'b00:   z = x + y;
        2'b01:   z = x - y + 16;
        default: z = x * y;
      endcase
      r[i*4 +: 4] = 4'(z % 16);
    end
    return r;
  endfunction

  task automatic scramble();
    addr_a = 3'($urandom); addr_b = 3'($urandom); addr_c = 3'($urandom);
    op = 4'($urandom); w_data = 16'($urandom); scalar = 4'($urandom);
  endtask

  task automatic do_cmd(input logic [3:0] o, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] c, input logic [3:0] sc, input logic [15:0] wd,
                        input bit now);
    int lat, kd, exp_lat;
    kd = kind_of(o);
    exp_lat = (kd == 3) ? 2 : NCH + 1;
    if (!now) begin
      @(negedge clk);
      check_eq("done_idle", done, 0);
    end
    check_eq("ready_idle", ready, 1);
    op = o; addr_a = a; addr_b = b; addr_c = c; scalar = sc; w_data = wd; v_in = 1;
    @(posedge clk); #1;
    v_in = 0;
    scramble();
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(negedge clk);
      if (done) lat = i;
    end
    check_eq("done_latency", lat, exp_lat);
    check_eq("ready_on_done", ready, 1);
    if (kd == 0) ref_regs[c] = wd;
    else if (kd == 2) ref_regs[c] = alu_ref(o, ref_regs[a], ref_regs[b], sc);
  endtask

  task automatic do_read(input logic [2:0] a, input logic [15:0] exp, input int hold);
    int lat;
    @(negedge clk);
    check_eq("ready_idle", ready, 1);
    op = 4'b1000; addr_a = a; v_in = 1;
    @(posedge clk); #1;
    v_in = 0;
    scramble();
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(negedge clk);
      if (v_out) lat = i;
    end
    check_eq("read_latency", lat, NCH + 1);
    check_eq("read_data", r_data, exp);
    check_eq("done_before_yumi", done, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_v", v_out, 1);
      check_eq("hold_ready", ready, 0);
      check_eq("hold_data", r_data, exp);
      check_eq("hold_done", done, 0);
    end
    yumi = 1; #1;
    check_eq("done_on_yumi", done, 1);
    @(posedge clk); #1;
    yumi = 0;
    @(negedge clk);
    check_eq("v_after_yumi", v_out, 0);
    check_eq("ready_after_yumi", ready, 1);
  endtask

  initial begin
    logic [3:0] ro;
    logic [2:0] ra, rb, rc;
    reset = 1; v_in = 0; yumi = 0; scramble();
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_v", v_out, 0);
    check_eq("rst_rdata", r_data, 0);
    reset = 0; #1;
    check_eq("ready_post_rst", ready, 1);

    do_cmd(4'b1001, 0, 0, 1, 0, 16'h0101, 0);
    do_cmd(4'b1001, 0, 0, 2, 0, 16'h1144, 1);
    do_read(1, 16'h0101, 0);
    do_cmd(4'b0000, 1, 2, 0, 0, 0, 0);
    do_read(0, 16'h1245, 1);
    do_cmd(4'b0001, 2, 1, 3, 0, 0, 0);
    do_read(3, 16'h1043, 0);
    do_cmd(4'b0001, 7, 1, 4, 0, 0, 0);
    do_read(4, 16'h0F0F, 0);
    do_cmd(4'b0010, 1, 3, 5, 0, 0, 0);
    do_read(5, 16'h0003, 0);
    do_cmd(4'b1001, 0, 0, 4, 0, 16'h4444, 0);
    do_cmd(4'b0010, 4, 4, 4, 0, 0, 0);
    do_read(4, 16'h0000, 0);
    do_cmd(4'b0100, 2, 0, 6, 3, 0, 0);
`ifdef VEC_SCALAR_OPS_EN
    do_read(6, 16'h4477, 5);
`else
    do_read(6, 16'h0000, 5);
`endif
    do_cmd(4'b0011, 1, 2, 1, 0, 0, 0);
    do_read(1, 16'h0101, 0);

    for (int t = 0; t < 40; t++) begin
      ra = 3'($urandom); rb = 3'($urandom); rc = 3'($urandom);
      case ($urandom_range(0, 4))
        0: do_cmd(4'b1001, ra, rb, rc, 4'($urandom), 16'($urandom), 0);
        1: do_read(ra, ref_regs[ra], $urandom_range(0, 3));
        2: do_cmd({2'b00, 2'($urandom_range(0, 2))}, ra, rb, rc, 4'($urandom), 16'($urandom), 0);
        3: do_cmd({2'b01, 2'($urandom_range(0, 2))}, ra, rb, rc, 4'($urandom), 16'($urandom), 0);
        default: begin
          ro = 4'($urandom);
          if (ro == 4'b1000) do_read(ra, ref_regs[ra], 0);
          else do_cmd(ro, ra, rb, rc, 4'($urandom), 16'($urandom), 0);
        end
      endcase
    end
    for (int i = 0; i < 8; i++) do_read(3'(i), ref_regs[i], 0);

    // Abort a write after its first chunk lands; everything must come back cleared.
    do_cmd(4'b1001, 0, 0, 7, 0, 16'hABCD, 0);
    do_read(7, 16'hABCD, 0);
    @(negedge clk);
    op = 4'b1001; addr_c = 3; w_data = 16'h5A5A; v_in = 1;
    @(posedge clk); #1;
    v_in = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1; #1;
    check_eq("midrst_ready", ready, 0);
    check_eq("midrst_v", v_out, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_rdata", r_data, 0);
    @(negedge clk);
    check_eq("midrst_done2", done, 0);
    reset = 0; #1;
    check_eq("midrst_ready_after", ready, 1);
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    repeat (3) begin
      @(negedge clk);
      check_eq("no_done_after_abort", done, 0);
    end
    for (int i = 0; i < 8; i++) do_read(3'(i), ref_regs[i], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
